key_write_arbiter: RTL and testbench

KEY_WRITE_ARBITER -- requirements
Module: key_write_arbiter

---
 rtl/accel_pkg.sv | 13 +
 rtl/key_write_arbiter_rr_pick.sv | 34 +++
 rtl/key_write_arbiter.sv | 105 ++++++++++
 tb/tb_key_write_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the key-queue write arbiter: default widths and FSM encoding.
package accel_pkg;

    localparam int DEF_NREQ  = 3;
    localparam int DEF_KEY_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/key_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first eligible requester at or after ptr.
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic             grant_valid,
    output logic [PTR_W-1:0] grant_idx
);

    int               cand;
    logic [PTR_W-1:0] candIdx;

    // Scan from the farthest offset down so the nearest eligible unit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        candIdx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            candIdx = PTR_W'(cand);
            if (eligible[candIdx]) begin
                grant_valid = 1'b1;
                grant_idx   = candIdx;
            end
        end
    end

endmodule

// File: rtl/key_write_arbiter.sv
// Arbitrates search-unit key writes into a shared key queue with round-robin fairness.
module key_write_arbiter
    import accel_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int KEY_W = DEF_KEY_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*KEY_W-1:0] key_in,
    input  logic                  q_full,
    input  logic                  q_afull,
    output logic [NREQ-1:0]       ack,
    output logic [KEY_W-1:0]      q_din,
    output logic                  q_wr_en,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           key_count
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state;
    arb_state_t       stateNext;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grantIdx;
    logic             grantValid;
    logic             grantFire;
    logic             runStart;
    logic [NREQ-1:0]  eligible;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A unit whose ack is showing still has req high; masking it avoids a double grant.
    assign eligible = req & ~ack;
    assign busy     = (state != IDLE);

    rr_pick #(
        .NREQ (NREQ),
        .PTR_W(PTR_W)
    ) uPick (
        .eligible   (eligible),
        .ptr        (ptr),
        .grant_valid(grantValid),
        .grant_idx  (grantIdx)
    );

    always_comb begin
        stateNext = state;
        runStart  = 1'b0;
        grantFire = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    stateNext = RUN;
                    runStart  = 1'b1;
                end
            end
            RUN: begin
                grantFire = grantValid && !q_full && !(q_afull && q_wr_en);
                if (stop) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                // Only the stop-cycle grant can be outstanding, and it lands on q_wr_en now.
                stateNext = IDLE;
                done      = 1'b1;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Grant stage -> queue write stage (one-cycle latency)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            ack       <= '0;
            q_wr_en   <= 1'b0;
            q_din     <= '0;
            key_count <= '0;
        end else begin
            state   <= stateNext;
            q_wr_en <= grantFire;
            ack     <= grantFire ? (NREQ'(1) << grantIdx) : '0;
            if (grantFire) begin
                q_din <= key_in[int'(grantIdx)*KEY_W +: KEY_W];
                ptr   <= (grantIdx == PTR_W'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
            end
            if (runStart) begin
                key_count <= '0;
            end else if (q_wr_en) begin
                key_count <= satInc(key_count);
            end
        end
    end

endmodule

// File: tb/tb_key_write_arbiter.sv
// Scenario bench for key_write_arbiter with a queue of expected queue writes.
module tb_key_write_arbiter;

    localparam int NREQ  = 3;
    localparam int KEY_W = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  stop;
    logic [NREQ-1:0]       req;
    logic [NREQ*KEY_W-1:0] key_in;
    logic                  q_full;
    logic                  q_afull;
    logic [NREQ-1:0]       ack;
    logic [KEY_W-1:0]      q_din;
    logic                  q_wr_en;
    logic                  busy;
    logic                  done;
    logic [15:0]           key_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NREQ-1:0]  ack;
        logic [KEY_W-1:0] key;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    always #5 clk = ~clk;

    key_write_arbiter #(.NREQ(NREQ), .KEY_W(KEY_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .req      (req),
        .key_in   (key_in),
        .q_full   (q_full),
        .q_afull  (q_afull),
        .ack      (ack),
        .q_din    (q_din),
        .q_wr_en  (q_wr_en),
        .busy     (busy),
        .done     (done),
        .key_count(key_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [KEY_W-1:0] unitKey(input int i);
        return key_in[i*KEY_W +: KEY_W];
    endfunction

    function automatic exp_t mkExp(input int i);
        exp_t x;
        x.ack = NREQ'(1) << i;
        x.key = unitKey(i);
        return x;
    endfunction

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; req = '0;
        q_full = 1'b0; q_afull = 1'b0;
        sbq.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        req = '0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int c = 0; c < 10 && busy; c++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s_drain busy=%b expected 0", tag, busy);
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++; $display("FAIL %s_sb_leftover got %0d pending expected 0", tag, sbq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; req = '0;
        q_full = 1'b0; q_afull = 1'b0; key_in = '0;
        #2;
        checks++;
        if ({q_wr_en, ack} !== 4'b0) begin
            errors++; $display("FAIL reset_wr_ack got %b%b expected 0000", q_wr_en, ack);
        end
        checks++;
        if (q_din !== '0 || key_count !== 16'd0) begin
            errors++; $display("FAIL reset_din_count got din=%h cnt=%h expected 0", q_din, key_count);
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_done got %b%b expected 00", busy, done);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || q_wr_en !== 1'b0) begin
            errors++; $display("FAIL reset_idle got busy=%b wr=%b expected 0", busy, q_wr_en);
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] nextReq;
        logic [NREQ-1:0] reRaise;
        int got;
        apply_reset();
        key_in = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) sbq.push_back(mkExp(i));
        start = 1'b1; req = 3'b111;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || key_count !== 16'd0) begin
            errors++; $display("FAIL fair_run_entry got busy=%b cnt=%0d expected 1/0", busy, key_count);
        end
        reRaise = '0; got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            nextReq = req | reRaise;
            reRaise = '0;
            if (q_wr_en) begin
                got++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL fair_write unexpected ack=%b din=%h", ack, q_din);
                end else begin
                    e = sbq.pop_front();
                    if (ack !== e.ack || q_din !== e.key) begin
                        errors++;
                        $display("FAIL fair_write got ack=%b din=%h expected ack=%b din=%h", ack, q_din, e.ack, e.key);
                    end
                end
            end
            for (int i = 0; i < NREQ; i++)
                if (ack[i]) begin nextReq[i] = 1'b0; reRaise[i] = 1'b1; end
            if (got >= 6) nextReq = '0;
            req = nextReq;
            tick();
        end
        checks++;
        if (got != 6) begin
            errors++; $display("FAIL fair_timeout got %0d writes expected 6", got);
        end
        checks++;
        if (key_count !== 16'd6 || q_wr_en !== 1'b0) begin
            errors++; $display("FAIL fair_count got cnt=%0d wr=%b expected 6/0", key_count, q_wr_en);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL fair_done got %b expected 1", done);
        end
        finish_run("fair");
    endtask

    task automatic test_backpressure();
        apply_reset();
        key_in = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        sbq.push_back(mkExp(1));
        start = 1'b1; q_full = 1'b1; req = 3'b010;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (q_wr_en !== 1'b0 || ack !== '0) begin
                errors++; $display("FAIL bp_blocked got wr=%b ack=%b expected 0", q_wr_en, ack);
            end
        end
        q_full = 1'b0;
        tick();
        checks++;
        if (q_wr_en !== 1'b1) begin
            errors++; $display("FAIL bp_release got wr=%b expected 1", q_wr_en);
        end else begin
            e = sbq.pop_front();
            if (ack !== e.ack || q_din !== e.key) begin
                errors++; $display("FAIL bp_write got ack=%b din=%h expected ack=%b din=%h", ack, q_din, e.ack, e.key);
            end
        end
        req = '0;
        tick();
        checks++;
        if (q_wr_en !== 1'b0 || ack !== '0 || key_count !== 16'd1) begin
            errors++; $display("FAIL bp_single got wr=%b ack=%b cnt=%0d expected 0/0/1", q_wr_en, ack, key_count);
        end
        finish_run("bp");
    endtask

    task automatic test_almost_full();
        apply_reset();
        key_in = {32'h5A5A_0002, 32'h4B4B_0001, 32'h3C3C_0000};
        sbq.push_back(mkExp(0));
        sbq.push_back(mkExp(2));
        req = 3'b101; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (q_wr_en !== 1'b1) begin
            errors++; $display("FAIL afull_first got wr=%b expected 1", q_wr_en);
        end else begin
            e = sbq.pop_front();
            if (ack !== e.ack || q_din !== e.key) begin
                errors++; $display("FAIL afull_first got ack=%b din=%h expected ack=%b din=%h", ack, q_din, e.ack, e.key);
            end
        end
        q_afull = 1'b1; req = 3'b100;
        tick();
        checks++;
        if (q_wr_en !== 1'b0 || ack !== '0) begin
            errors++; $display("FAIL afull_hold got wr=%b ack=%b expected 0", q_wr_en, ack);
        end
        tick();
        checks++;
        if (q_wr_en !== 1'b1) begin
            errors++; $display("FAIL afull_resume got wr=%b expected 1", q_wr_en);
        end else begin
            e = sbq.pop_front();
            if (ack !== e.ack || q_din !== e.key) begin
                errors++; $display("FAIL afull_resume got ack=%b din=%h expected ack=%b din=%h", ack, q_din, e.ack, e.key);
            end
        end
        req = '0; q_afull = 1'b0;
        finish_run("afull");
    endtask

    task automatic test_stop_inflight();
        apply_reset();
        key_in = {32'h0000_0C02, 32'hDEAD_BEEF, 32'h0000_0A00};
        start = 1'b1;
        tick();
        start = 1'b0; req = 3'b010; stop = 1'b1;
        sbq.push_back(mkExp(1));
        tick();
        stop = 1'b0; req = '0;
        checks++;
        if (q_wr_en !== 1'b1) begin
            errors++; $display("FAIL stop_write got wr=%b expected 1", q_wr_en);
        end else begin
            e = sbq.pop_front();
            if (ack !== e.ack || q_din !== e.key) begin
                errors++; $display("FAIL stop_write got ack=%b din=%h expected ack=%b din=%h", ack, q_din, e.ack, e.key);
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL stop_done got done=%b busy=%b expected 1/1", done, busy);
        end
        tick();
        checks++;
        if ({busy, done, q_wr_en} !== 3'b000 || key_count !== 16'd1) begin
            errors++; $display("FAIL stop_idle got busy=%b done=%b wr=%b cnt=%0d expected 0/0/0/1", busy, done, q_wr_en, key_count);
        end
        checks++;
        if (q_din !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL stop_din_hold got %h expected deadbeef", q_din);
        end
    endtask

    task automatic test_start_stop();
        apply_reset();
        req = 3'b111; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL startstop_busy got %b expected 0", busy);
        end
        tick();
        checks++;
        if (q_wr_en !== 1'b0 || ack !== '0) begin
            errors++; $display("FAIL startstop_nogrant got wr=%b ack=%b expected 0", q_wr_en, ack);
        end
        req = '0;
    endtask

    task automatic test_reset_midgrant();
        apply_reset();
        key_in = {32'h7777_0002, 32'h6666_0001, 32'h5555_0000};
        req = 3'b001; start = 1'b1;
        tick();
        start = 1'b0;
        #2 rst = 1'b1;
        tick();
        checks++;
        if (q_wr_en !== 1'b0 || ack !== '0) begin
            errors++; $display("FAIL rst_pending got wr=%b ack=%b expected 0", q_wr_en, ack);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || q_wr_en !== 1'b0) begin
            errors++; $display("FAIL rst_abandon got busy=%b wr=%b expected 0", busy, q_wr_en);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (q_wr_en !== 1'b1 || ack !== 3'b001 || key_count !== 16'd1) begin
            errors++; $display("FAIL rst_prewrite got wr=%b ack=%b cnt=%0d expected 1/001/1", q_wr_en, ack, key_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (q_wr_en !== 1'b0 || ack !== '0 || key_count !== 16'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_async got wr=%b ack=%b cnt=%0d busy=%b expected 0", q_wr_en, ack, key_count, busy);
        end
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        int w;
        apply_reset();
        key_in = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
        req = 3'b111; start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        for (int c = 0; c < 70000 && w < 65540; c++) begin
            if (q_wr_en) w++;
            tick();
        end
        req = '0;
        checks++;
        if (w != 65540) begin
            errors++; $display("FAIL sat_timeout got %0d writes expected 65540", w);
        end
        tick();
        tick();
        checks++;
        if (key_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_run got %h expected ffff", key_count);
        end
        finish_run("sat");
        checks++;
        if (key_count !== 16'hFFFF) begin
            errors++; $display("FAIL sat_idle_hold got %h expected ffff", key_count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (key_count !== 16'd0) begin
            errors++; $display("FAIL sat_restart got %h expected 0000", key_count);
        end
        finish_run("sat2");
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
        test_almost_full();
        test_stop_inflight();
        test_start_stop();
        test_reset_midgrant();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
